axi_memory_responder: RTL and testbench
=======================================

# axi_memory_responder

Single-clock AXI slave that terminates the external-memory side of `memory_arbiter`. It accepts read and write bursts (ID 4 bits, LEN 4 bits, up to 16 words; caches use 2–8) into a word-addressed backing RAM. It returns ordered read-data bursts and write responses. It is the simulation and FPGA memory endpoint for the MIPS core.

## Interface
Parameters:
- `DEPTH`, default 1024: RAM size in `DATA_WIDTH` words. Must be a power of 2.
- `READ_LATENCY`, default 4: idle cycles between AR handshake and first R beat. Used only with `AXI_MEM_LATENCY_EN`. Legal range 0–15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `axi_write_address`  `axi_write_address.slave`  –  AWVALID/AWREADY, AWID[3:0], AWLEN[3:0], AWADDR[`ADDR_WIDTH`-1:0].
- `axi_write_data`  `axi_write_data.slave`  –  WVALID/WREADY, WID[3:0], WLAST, WDATA[`DATA_WIDTH`-1:0].
- `axi_write_response`  `axi_write_response.slave`  –  BVALID/BREADY, BID[3:0].
- `axi_read_address`  `axi_read_address.slave`  –  ARVALID/ARREADY, ARID[3:0], ARLEN[3:0], ARADDR.
- `axi_read_data`  `axi_read_data.slave`  –  RVALID/RREADY, RID[3:0], RLAST, RDATA.
- `protocol_error`  out  1  sticky flag; set on a WLAST/beat-count mismatch; cleared only by reset.

## Operation
- Addressing: word index = ADDR[$clog2(DEPTH)+1:2]. Byte bits [1:0] are ignored. Each beat increments the index by 1, modulo DEPTH (wraps at the top of RAM).
- Beats per burst = LEN+1, range 1–16.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch AWID, AWLEN and start index, then go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes WDATA to RAM and increments the beat counter. WID is ignored.
  - The burst ends on whichever comes first: WLAST=1, or beat counter == AWLEN.
  - If those two disagree, `protocol_error` is set, and that beat is still the final one.
  - At burst end, go to W_RESP.
  - W_RESP: BVALID=1, BID=latched AWID. On BREADY, go to W_IDLE.
- Read FSM, states R_IDLE, R_WAIT, R_BURST:
  - R_IDLE: ARREADY=1. On AR handshake, latch ARID, ARLEN and start index.
  - R_WAIT: counts down the latency (macro only).
  - R_BURST: RVALID=1, RID=latched ARID, RDATA=RAM[index], RLAST=(beat==ARLEN).
  - Each R handshake advances the beat. The handshake on RLAST returns to R_IDLE.
- Read and write FSMs run independently and concurrently. One read burst and one write burst can be outstanding at a time.
- Same-word read/write collision in one cycle: the R beat returns the old data (read-before-write). The write takes effect on the following cycle.
- RAM contents are not reset. Contents persist across `rst_n`.

## Timing
- Reset (asynchronous, immediate): both FSMs go to IDLE and beat counters clear.
- Output values while `rst_n`=0: AWREADY=0, ARREADY=0, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BID/RID=0, RDATA=0, `protocol_error`=0.
- All handshake outputs are registered. AWREADY and ARREADY rise on the first clock edge after `rst_n` is released.
- Write path:
  - AW handshake at edge N: AWREADY=0 and WREADY=1 from N+1. Same-cycle AW+W is not accepted.
  - Final W handshake at edge M: WREADY=0 and BVALID=1 from M+1.
  - B handshake at edge K: BVALID=0 and AWREADY=1 from K+1.
- Read path:
  - AR handshake at edge N: ARREADY=0 from N+1.
  - First RVALID at N+1 without the macro, or at N+1+READ_LATENCY with it.
  - While RVALID=1 and RREADY=0, RDATA/RID/RLAST hold stable.
  - Back-to-back beats stream at 1 per cycle while RREADY=1.
  - Last R handshake at edge K: RVALID=0 and ARREADY=1 from K+1.
- Reset mid-burst: the partial write is kept in RAM. No B or R beat is issued for the aborted bursts.

## Configuration
- `AXI_MEM_LATENCY_EN` defined:
  - R_WAIT is compiled in and holds for READ_LATENCY cycles.
  - A 4-bit down-counter is loaded at the AR handshake.
  - READ_LATENCY=0 behaves identically to the undefined case.
- `AXI_MEM_LATENCY_EN` undefined:
  - R_WAIT and its counter are absent.
  - Minimum read latency is 1 cycle from the AR handshake to the first RVALID.

## Test plan
- Reset release: check every output held at its reset value while `rst_n`=0 → AWREADY=ARREADY=1 one cycle after release.
- Write then read back: AW addr 0x40, LEN 3, ID 0; W data 0xA0–0xA3 with WLAST on beat 3 → BVALID with BID=0. Then AR 0x40, LEN 3, ID 1 → RDATA 0xA0–0xA3, RID=1, RLAST only on beat 3.
- Backpressure: read LEN 7 with RREADY toggled 1,0,0,1,… → each RDATA held stable while stalled, 8 beats total, no beat lost or duplicated.
- Wrap and mismatch:
  - Write at word DEPTH-2, LEN 3 → words DEPTH-2, DEPTH-1, 0, 1 written.
  - Separately, WLAST on beat 1 of a LEN 3 burst → burst ends, BVALID asserted, `protocol_error`=1 and it stays 1.
- Concurrency/collision: read of word 5 issued in the same cycle that a W beat writes word 5 = 0xBEEF → R returns the old value; a subsequent read returns 0xBEEF.
- Latency and async reset, with `AXI_MEM_LATENCY_EN` and READ_LATENCY=4:
  - First RVALID 5 cycles after the AR handshake.
  - Asserting `rst_n`=0 mid-burst drops RVALID immediately, with no clock edge needed.

Source files
------------

// File: rtl/axi_memory_responder_if.sv
// AXI channel interfaces for the memory responder.
// One interface per channel; slave modports face the RAM endpoint.
interface axi_write_address #(
  parameter int ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [3:0]            awid;
  logic [3:0]            awlen;
  logic [ADDR_WIDTH-1:0] awaddr;
  modport master (output awvalid, awid, awlen, awaddr, input awready);
  modport slave  (input awvalid, awid, awlen, awaddr, output awready);
endinterface

interface axi_write_data #(
  parameter int DATA_WIDTH = 32
);
  logic                  wvalid;
  logic                  wready;
  logic [3:0]            wid;
  logic                  wlast;
  logic [DATA_WIDTH-1:0] wdata;
  modport master (output wvalid, wid, wlast, wdata, input wready);
  modport slave  (input wvalid, wid, wlast, wdata, output wready);
endinterface

interface axi_write_response;
  logic       bvalid;
  logic       bready;
  logic [3:0] bid;
  modport master (input bvalid, bid, output bready);
  modport slave  (output bvalid, bid, input bready);
endinterface

interface axi_read_address #(
  parameter int ADDR_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [3:0]            arid;
  logic [3:0]            arlen;
  logic [ADDR_WIDTH-1:0] araddr;
  modport master (output arvalid, arid, arlen, araddr, input arready);
  modport slave  (input arvalid, arid, arlen, araddr, output arready);
endinterface

interface axi_read_data #(
  parameter int DATA_WIDTH = 32
);
  logic                  rvalid;
  logic                  rready;
  logic [3:0]            rid;
  logic                  rlast;
  logic [DATA_WIDTH-1:0] rdata;
  modport master (input rvalid, rid, rlast, rdata, output rready);
  modport slave  (output rvalid, rid, rlast, rdata, input rready);
endinterface

// File: rtl/axi_memory_responder.sv
// AXI burst slave over a word-addressed RAM with independent R/W FSMs.
// Define AXI_MEM_LATENCY_EN to insert READ_LATENCY idle cycles before R data.
module axi_memory_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_write_address.slave  axi_write_address,
  axi_write_data.slave     axi_write_data,
  axi_write_response.slave axi_write_response,
  axi_read_address.slave   axi_read_address,
  axi_read_data.slave      axi_read_data,
  output logic             protocol_error
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [1:0] R_IDLE  = 2'd0;
`ifdef AXI_MEM_LATENCY_EN
  localparam logic [1:0] R_WAIT  = 2'd1;
`endif
  localparam logic [1:0] R_BURST = 2'd2;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [1:0]            r_wstate;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [3:0]            r_bid;
  logic [3:0]            r_awlen;
  logic [3:0]            r_wcnt;
  logic [IW-1:0]         r_widx;
  logic                  r_perr;

  logic [1:0]            r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [3:0]            r_rid;
  logic [3:0]            r_rlen;
  logic [3:0]            r_rcnt;
  logic [IW-1:0]         r_ridx;
  logic [DATA_WIDTH-1:0] r_rdata;
`ifdef AXI_MEM_LATENCY_EN
  logic [3:0]            r_lat;
`endif

  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_cnt_hit;
  logic w_unused_ok;

  assign w_aw_hs   = axi_write_address.awvalid & r_awready;
  assign w_w_hs    = axi_write_data.wvalid & r_wready;
  assign w_b_hs    = axi_write_response.bready & r_bvalid;
  assign w_ar_hs   = axi_read_address.arvalid & r_arready;
  assign w_r_hs    = axi_read_data.rready & r_rvalid;
  assign w_cnt_hit = (r_wcnt == r_awlen);

  // Byte lanes, upper address bits and WID carry no meaning here.
  assign w_unused_ok = ^{axi_write_address.awaddr,
                         axi_read_address.araddr,
                         axi_write_data.wid};

  always_ff @(posedge clk) begin
    if (w_w_hs) r_mem[r_widx] <= axi_write_data.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= 4'd0;
      r_awlen   <= 4'd0;
      r_wcnt    <= 4'd0;
      r_widx    <= '0;
      r_perr    <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_bid     <= axi_write_address.awid;
            r_awlen   <= axi_write_address.awlen;
            r_widx    <= axi_write_address.awaddr[IW+1:2];
            r_wcnt    <= 4'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_widx <= r_widx + IW'(1);
            r_wcnt <= r_wcnt + 4'd1;
            if (axi_write_data.wlast | w_cnt_hit) begin
              if (axi_write_data.wlast != w_cnt_hit) r_perr <= 1'b1;
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // RDATA is registered from RAM so a same-cycle write to the beat's
  // word lands after the beat is captured (read-before-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= 4'd0;
      r_rlen    <= 4'd0;
      r_rcnt    <= 4'd0;
      r_ridx    <= '0;
      r_rdata   <= '0;
`ifdef AXI_MEM_LATENCY_EN
      r_lat     <= 4'd0;
`endif
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_rid     <= axi_read_address.arid;
            r_rlen    <= axi_read_address.arlen;
            r_ridx    <= axi_read_address.araddr[IW+1:2];
            r_rcnt    <= 4'd0;
            r_arready <= 1'b0;
`ifdef AXI_MEM_LATENCY_EN
            if (READ_LATENCY != 0) begin
              r_lat    <= 4'(READ_LATENCY - 1);
              r_rstate <= R_WAIT;
            end else begin
`else
            begin
`endif
              r_rdata  <= r_mem[axi_read_address.araddr[IW+1:2]];
              r_rlast  <= (axi_read_address.arlen == 4'd0);
              r_rvalid <= 1'b1;
              r_rstate <= R_BURST;
            end
          end
        end
`ifdef AXI_MEM_LATENCY_EN
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            r_rdata  <= r_mem[r_ridx];
            r_rlast  <= (r_rlen == 4'd0);
            r_rvalid <= 1'b1;
            r_rstate <= R_BURST;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
`endif
        R_BURST: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_rdata   <= '0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_ridx  <= r_ridx + IW'(1);
              r_rcnt  <= r_rcnt + 4'd1;
              r_rdata <= r_mem[r_ridx + IW'(1)];
              r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi_write_address.awready = r_awready;
  assign axi_write_data.wready     = r_wready;
  assign axi_write_response.bvalid = r_bvalid;
  assign axi_write_response.bid    = r_bid;
  assign axi_read_address.arready  = r_arready;
  assign axi_read_data.rvalid      = r_rvalid;
  assign axi_read_data.rlast       = r_rlast;
  assign axi_read_data.rid         = r_rid;
  assign axi_read_data.rdata       = r_rdata;
  assign protocol_error            = r_perr;

endmodule

// File: tb/tb_axi_memory_responder.sv
// Self-checking bench for axi_memory_responder.
// Reference: word array updated per accepted W beat, read back per R beat.
module tb_axi_memory_responder;

  localparam int DEPTH = 1024;
`ifdef AXI_MEM_LATENCY_EN
  localparam int EXP_LAT = 5;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic perr;

  axi_write_address  #(.ADDR_WIDTH(32)) aw();
  axi_write_data     #(.DATA_WIDTH(32)) w();
  axi_write_response                    b();
  axi_read_address   #(.ADDR_WIDTH(32)) ar();
  axi_read_data      #(.DATA_WIDTH(32)) r();

  axi_memory_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(4),
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .axi_write_address(aw),
    .axi_write_data(w),
    .axi_write_response(b),
    .axi_read_address(ar),
    .axi_read_data(r),
    .protocol_error(perr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string what);
    n_vec++; n_err++;
    $display("FAIL timeout_%s: no handshake within budget, required one", what);
  endtask

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'(DEPTH - 1));
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len,
                          input logic [3:0] id, input int last_beat,
                          input bit gaps, input bit fixed,
                          input logic [31:0] base,
                          output logic [3:0] got_bid, output int b_wait);
    int t, nb, idx;
    logic [31:0] d;
    aw.awaddr = addr; aw.awlen = 4'(len); aw.awid = id; aw.awvalid = 1'b1;
    t = 0;
    while (aw.awready !== 1'b1 && t < 50) begin step(); t++; end
    if (t >= 50) timeout("aw");
    step();
    aw.awvalid = 1'b0;
    nb = (last_beat < len) ? last_beat + 1 : len + 1;
    idx = widx(addr);
    for (int i = 0; i < nb; i++) begin
      if (gaps) while ($urandom_range(0, 2) == 0) step();
      d = fixed ? base + 32'(i) : $urandom;
      w.wdata = d; w.wid = 4'($urandom);
      w.wlast = (i == last_beat); w.wvalid = 1'b1;
      t = 0;
      while (w.wready !== 1'b1 && t < 50) begin step(); t++; end
      if (t >= 50) timeout("w");
      step();
      model[(idx + i) % DEPTH] = d;
      w.wvalid = 1'b0; w.wlast = 1'b0;
    end
    b_wait = 0;
    while (b.bvalid !== 1'b1 && b_wait < 50) begin step(); b_wait++; end
    if (b_wait >= 50) timeout("b");
    got_bid = b.bid;
    b.bready = 1'b1;
    step();
    b.bready = 1'b0;
  endtask

  // mode 0: RREADY high, 1: pattern 1,0,0 repeating, 2: random
  task automatic do_read(input logic [31:0] addr, input int len,
                         input logic [3:0] id, input int mode,
                         output int lat, output int nbeats,
                         output int bad_data, output int bad_id,
                         output int bad_last, output int unstable,
                         output int span, output bit post_ok);
    int t, idx, beat, k;
    bit done, held;
    logic [31:0] hd;
    logic [3:0] hid;
    logic hl;
    bad_data = 0; bad_id = 0; bad_last = 0; unstable = 0;
    held = 0; hd = '0; hid = '0; hl = 1'b0;
    ar.araddr = addr; ar.arlen = 4'(len); ar.arid = id; ar.arvalid = 1'b1;
    t = 0;
    while (ar.arready !== 1'b1 && t < 50) begin step(); t++; end
    if (t >= 50) timeout("ar");
    step();
    ar.arvalid = 1'b0;
    idx = widx(addr);
    lat = 1;
    while (r.rvalid !== 1'b1 && lat < 40) begin step(); lat++; end
    if (lat >= 40) timeout("rvalid");
    beat = 0; span = 0; done = 0; k = 0;
    while (!done && span < 300) begin
      case (mode)
        0: r.rready = 1'b1;
        1: r.rready = (k % 3 == 0);
        default: r.rready = 1'($urandom_range(0, 1));
      endcase
      if (r.rvalid === 1'b1) begin
        if (held && (r.rdata !== hd || r.rid !== hid || r.rlast !== hl))
          unstable++;
        if (r.rready) begin
          if (r.rdata !== model[(idx + beat) % DEPTH]) bad_data++;
          if (r.rid !== id) bad_id++;
          if (r.rlast !== (beat == len)) bad_last++;
          if (r.rlast === 1'b1 || beat == len) done = 1;
          beat++;
          held = 0;
        end else begin
          held = 1; hd = r.rdata; hid = r.rid; hl = r.rlast;
        end
      end
      step();
      span++; k++;
    end
    r.rready = 1'b0;
    if (!done) timeout("rburst");
    nbeats = beat;
    post_ok = (r.rvalid === 1'b0 && ar.arready === 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_vec++; if (aw.awready !== 1'b0) begin n_err++; $display("FAIL rst_awready: got %b want 0", aw.awready); end
    n_vec++; if (ar.arready !== 1'b0) begin n_err++; $display("FAIL rst_arready: got %b want 0", ar.arready); end
    n_vec++; if (w.wready !== 1'b0) begin n_err++; $display("FAIL rst_wready: got %b want 0", w.wready); end
    n_vec++; if (b.bvalid !== 1'b0 || b.bid !== 4'd0) begin n_err++; $display("FAIL rst_b: got v=%b id=%h want 0/0", b.bvalid, b.bid); end
    n_vec++; if (r.rvalid !== 1'b0 || r.rlast !== 1'b0) begin n_err++; $display("FAIL rst_r: got v=%b l=%b want 0/0", r.rvalid, r.rlast); end
    n_vec++; if (r.rid !== 4'd0 || r.rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got id=%h d=%h want 0/0", r.rid, r.rdata); end
    n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", perr); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (aw.awready !== 1'b0) begin n_err++; $display("FAIL rel_awready_early: got %b want 0", aw.awready); end
    step();
    n_vec++; if (aw.awready !== 1'b1 || ar.arready !== 1'b1) begin n_err++; $display("FAIL rel_ready: got aw=%b ar=%b want 1/1", aw.awready, ar.arready); end
  endtask

  task automatic test_write_read();
    logic [3:0] bid; int bw, lat, nb, bd, bi, bl, us, sp; bit pk;
    do_write(32'h40, 3, 4'd0, 3, 0, 1, 32'hA0, bid, bw);
    n_vec++; if (bid !== 4'd0 || bw != 0) begin n_err++; $display("FAIL wr_b: got bid=%h wait=%0d want 0/0", bid, bw); end
    do_read(32'h40, 3, 4'd1, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL rd_latency: got %0d want %0d", lat, EXP_LAT); end
    n_vec++; if (nb != 4 || bd != 0) begin n_err++; $display("FAIL rd_data: got beats=%0d bad=%0d want 4/0", nb, bd); end
    n_vec++; if (bi != 0 || bl != 0) begin n_err++; $display("FAIL rd_id_last: got badid=%0d badlast=%0d want 0/0", bi, bl); end
    n_vec++; if (!pk) begin n_err++; $display("FAIL rd_post: got rvalid=%b arready=%b want 0/1", r.rvalid, ar.arready); end
    n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL wr_perr: got %b want 0", perr); end
  endtask

  task automatic test_backpressure();
    logic [3:0] bid; int bw, lat, nb, bd, bi, bl, us, sp; bit pk;
    do_write(32'h200, 7, 4'd5, 7, 1, 0, 32'h0, bid, bw);
    n_vec++; if (bid !== 4'd5) begin n_err++; $display("FAIL bp_bid: got %h want 5", bid); end
    do_read(32'h200, 7, 4'd6, 1, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (nb != 8 || bd != 0 || bl != 0) begin n_err++; $display("FAIL bp_beats: got beats=%0d bad=%0d badlast=%0d want 8/0/0", nb, bd, bl); end
    n_vec++; if (us != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes while stalled want 0", us); end
    n_vec++; if (!pk || bi != 0) begin n_err++; $display("FAIL bp_post: got post=%b badid=%0d want 1/0", pk, bi); end
  endtask

  task automatic test_wrap();
    logic [3:0] bid; int bw, lat, nb, bd, bi, bl, us, sp; bit pk;
    do_write(32'((DEPTH - 2) * 4), 3, 4'd7, 3, 0, 0, 32'h0, bid, bw);
    n_vec++; if (bid !== 4'd7) begin n_err++; $display("FAIL wrap_bid: got %h want 7", bid); end
    do_read(32'((DEPTH - 2) * 4), 3, 4'd8, 2, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (nb != 4 || bd != 0 || bl != 0) begin n_err++; $display("FAIL wrap_read: got beats=%0d bad=%0d want 4/0", nb, bd); end
    do_read(32'h0, 1, 4'd9, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (nb != 2 || bd != 0) begin n_err++; $display("FAIL wrap_low: got beats=%0d bad=%0d want 2/0", nb, bd); end
  endtask

  task automatic test_mismatch();
    logic [3:0] bid; int bw, lat, nb, bd, bi, bl, us, sp; bit pk;
    n_vec++; if (perr !== 1'b0) begin n_err++; $display("FAIL mm_pre: got %b want 0", perr); end
    do_write(32'h300, 3, 4'd2, 1, 0, 0, 32'h0, bid, bw);
    n_vec++; if (bid !== 4'd2 || bw != 0) begin n_err++; $display("FAIL mm_b: got bid=%h wait=%0d want 2/0", bid, bw); end
    n_vec++; if (perr !== 1'b1) begin n_err++; $display("FAIL mm_perr: got %b want 1", perr); end
    do_read(32'h300, 1, 4'd3, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (bd != 0 || nb != 2) begin n_err++; $display("FAIL mm_data: got bad=%0d beats=%0d want 0/2", bd, nb); end
    do_write(32'h340, 0, 4'd4, 0, 0, 0, 32'h0, bid, bw);
    n_vec++; if (perr !== 1'b1) begin n_err++; $display("FAIL mm_sticky: got %b want 1", perr); end
  endtask

  task automatic test_collision();
    logic [3:0] bid; int bw, t, lat, nb, bd, bi, bl, us, sp; bit pk;
    logic [31:0] old, exp_d, got;
    do_write(32'd20, 0, 4'd1, 0, 0, 0, 32'h0, bid, bw);
    old = model[5];
    aw.awaddr = 32'd20; aw.awlen = 4'd0; aw.awid = 4'd3; aw.awvalid = 1'b1;
    t = 0;
    while (aw.awready !== 1'b1 && t < 50) begin step(); t++; end
    if (t >= 50) timeout("col_aw");
    step();
    aw.awvalid = 1'b0;
    n_vec++; if (w.wready !== 1'b1 || ar.arready !== 1'b1) begin n_err++; $display("FAIL col_ready: got wready=%b arready=%b want 1/1", w.wready, ar.arready); end
    w.wdata = 32'hBEEF; w.wlast = 1'b1; w.wvalid = 1'b1;
    ar.araddr = 32'd20; ar.arlen = 4'd0; ar.arid = 4'd4; ar.arvalid = 1'b1;
    step();
    w.wvalid = 1'b0; w.wlast = 1'b0; ar.arvalid = 1'b0;
    t = 0;
    while (r.rvalid !== 1'b1 && t < 40) begin step(); t++; end
    if (t >= 40) timeout("col_r");
    got = r.rdata;
    r.rready = 1'b1;
    step();
    r.rready = 1'b0;
`ifdef AXI_MEM_LATENCY_EN
    exp_d = 32'hBEEF;
`else
    exp_d = old;
`endif
    n_vec++; if (got !== exp_d) begin n_err++; $display("FAIL col_old: got %h want %h", got, exp_d); end
    t = 0;
    while (b.bvalid !== 1'b1 && t < 40) begin step(); t++; end
    if (t >= 40) timeout("col_b");
    b.bready = 1'b1;
    step();
    b.bready = 1'b0;
    model[5] = 32'hBEEF;
    do_read(32'd20, 0, 4'd5, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (bd != 0 || nb != 1) begin n_err++; $display("FAIL col_new: got bad=%0d beats=%0d want 0/1", bd, nb); end
  endtask

  task automatic test_random();
    logic [3:0] bid, id; int bw, lat, nb, bd, bi, bl, us, sp, len; bit pk;
    logic [31:0] addr;
    for (int it = 0; it < 8; it++) begin
      addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      len = $urandom_range(0, 15);
      id = 4'($urandom);
      do_write(addr, len, id, len, 1, 0, 32'h0, bid, bw);
      n_vec++; if (bid !== id) begin n_err++; $display("FAIL rnd_bid[%0d]: got %h want %h", it, bid, id); end
      do_read(addr, len, ~id, 2, lat, nb, bd, bi, bl, us, sp, pk);
      n_vec++; if (nb != len + 1 || bd != 0 || bi != 0 || bl != 0 || us != 0 || !pk) begin
        n_err++;
        $display("FAIL rnd_read[%0d]: got beats=%0d bad=%0d badid=%0d badlast=%0d unstable=%0d post=%b want %0d/0/0/0/0/1",
                 it, nb, bd, bi, bl, us, pk, len + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bid; int bw, lat, nb, bd, bi, bl, us, sp; bit pk;
    do_write(32'h800, 15, 4'hA, 15, 0, 0, 32'h0, bid, bw);
    do_read(32'h800, 15, 4'hB, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (sp != 16 || nb != 16) begin n_err++; $display("FAIL b2b_rate: got cycles=%0d beats=%0d want 16/16", sp, nb); end
    n_vec++; if (bd != 0 || bl != 0) begin n_err++; $display("FAIL b2b_data: got bad=%0d badlast=%0d want 0/0", bd, bl); end
  endtask

  task automatic test_latency_async_reset();
    int t, lat, nb, bd, bi, bl, us, sp; bit pk;
    ar.araddr = 32'h40; ar.arlen = 4'd7; ar.arid = 4'd2; ar.arvalid = 1'b1;
    t = 0;
    while (ar.arready !== 1'b1 && t < 50) begin step(); t++; end
    if (t >= 50) timeout("lat_ar");
    step();
    ar.arvalid = 1'b0;
    lat = 1;
    while (r.rvalid !== 1'b1 && lat < 40) begin step(); lat++; end
    n_vec++; if (lat != EXP_LAT) begin n_err++; $display("FAIL lat_first: got %0d want %0d", lat, EXP_LAT); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (r.rvalid !== 1'b0 || r.rlast !== 1'b0 || r.rdata !== 32'd0) begin n_err++; $display("FAIL async_r: got v=%b l=%b d=%h want 0/0/0", r.rvalid, r.rlast, r.rdata); end
    n_vec++; if (ar.arready !== 1'b0 || aw.awready !== 1'b0 || perr !== 1'b0) begin n_err++; $display("FAIL async_misc: got ar=%b aw=%b perr=%b want 0/0/0", ar.arready, aw.awready, perr); end
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (ar.arready !== 1'b1 || r.rvalid !== 1'b0) begin n_err++; $display("FAIL async_rel: got ar=%b rvalid=%b want 1/0", ar.arready, r.rvalid); end
    do_read(32'h40, 3, 4'd6, 0, lat, nb, bd, bi, bl, us, sp, pk);
    n_vec++; if (bd != 0 || nb != 4) begin n_err++; $display("FAIL persist: got bad=%0d beats=%0d want 0/4", bd, nb); end
  endtask

  initial begin
    aw.awvalid = 1'b0; aw.awid = '0; aw.awlen = '0; aw.awaddr = '0;
    w.wvalid = 1'b0; w.wid = '0; w.wlast = 1'b0; w.wdata = '0;
    b.bready = 1'b0;
    ar.arvalid = 1'b0; ar.arid = '0; ar.arlen = '0; ar.araddr = '0;
    r.rready = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_mismatch();
    test_collision();
    test_random();
    test_back_to_back();
    test_latency_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule
